// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared logic/shift unit.
// Two requester channels (valid/ready + op/operands) and one tagged
// response channel. The master side is the requesters plus the result
// consumer; the slave side is the arbiter itself.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_res;
    logic             busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_res, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_res, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared logic/shift unit for two requesters.
// Logic ops resolve in one EXEC cycle; shifts walk one bit per cycle
// under a down-counter. The result is held in RESP, tagged with the
// owner's id, until the consumer takes it.
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    state_t             state_reg;
    // Port favoured on a tie: always the one opposite the last grant.
    logic               rr_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [SHW-1:0]     cnt_reg;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               id_reg;

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic [2:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   shift_step;
    logic               is_shift;

    // Arbitration: single valid wins outright, ties go to the favoured port.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !rr_reg);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_reg);
    end

    assign bus.req0_ready = (state_reg == IDLE) && grant0;
    assign bus.req1_ready = (state_reg == IDLE) && grant1;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign sel_op = bus.req1_ready ? bus.req1_op : bus.req0_op;
    assign sel_a  = bus.req1_ready ? bus.req1_a  : bus.req0_a;
    assign sel_b  = bus.req1_ready ? bus.req1_b  : bus.req0_b;

    // Single-cycle logic result from the latched operands; reserved gives 0.
    always_comb begin
        case (op_reg)
            OP_AND:  logic_res = a_reg & b_reg;
            OP_OR:   logic_res = a_reg | b_reg;
            OP_XOR:  logic_res = a_reg ^ b_reg;
            OP_NOR:  logic_res = ~(a_reg | b_reg);
            default: logic_res = '0;
        endcase
    end

    // One-bit shift of the accumulator for the current shift op.
    always_comb begin
        case (op_reg)
            OP_SLL:  shift_step = {acc_reg[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, acc_reg[WIDTH-1:1]};
            OP_SRA:  shift_step = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
            default: shift_step = acc_reg;
        endcase
    end

    assign is_shift = (op_reg == OP_SLL) || (op_reg == OP_SRL) || (op_reg == OP_SRA);

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            id_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= sel_op;
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        id_reg    <= bus.req1_ready;
                        acc_reg   <= sel_a;
                        cnt_reg   <= sel_b[SHW-1:0];
                        rr_reg    <= !bus.req1_ready;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (!is_shift) begin
                        acc_reg   <= logic_res;
                        state_reg <= RESP;
                    end else if (cnt_reg != '0) begin
                        acc_reg <= shift_step;
                        cnt_reg <= cnt_reg - {{(SHW-1){1'b0}}, 1'b1};
                    end else begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_res   = acc_reg;
    assign bus.rsp_id    = id_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule
